camera_frame_sequencer: RTL and testbench

Write-side controller for the 320x240 camera framebuffer BRAM in the pixel clock domain. It sits between camera_read and port A of the framebuffer. It generates the write address, data and enable, aligns capture to frame boundaries, and supports continuous (live) or single-frame (snapshot/freeze) capture. It also reports per-frame completion status, so debug drawing and vision consumers only see whole, correctly sized frames.

---
 rtl/camera_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_camera_frame_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_sequencer.sv
// rtl/camera_frame_sequencer.sv - framebuffer write-side capture sequencer (optional stats: CAMERA_FRAME_STATS_EN)
module camera_frame_sequencer #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  pixel_clock_in,
    input  logic                  reset_in,
    input  logic [15:0]           pixel_data,
    input  logic                  pixel_valid,
    input  logic                  frame_done,
    input  logic                  live_mode,
    input  logic                  snapshot_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [11:0]           wr_data,
    output logic                  wr_en,
    output logic                  frame_ready,
    output logic                  frame_error,
    output logic                  busy,
    output logic                  holding
`ifdef CAMERA_FRAME_STATS_EN
    ,output logic [15:0]          frame_count
    ,output logic [16:0]          last_pixel_count
`endif
);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PIX_FULL = ADDR_WIDTH'(FRAME_PIXELS);
    localparam logic [16:0]           SEEN_MAX = 17'h1FFFF;

    state_t                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]   pix_cnt_q;
    logic                    ovf_q;
    logic [16:0]             seen_q;

    logic                    in_capture;
    logic                    accept;
    logic                    drop;
    logic [ADDR_WIDTH-1:0]   cnt_end;
    logic                    ovf_end;
    logic [16:0]             seen_end;
    logic                    end_capture;
    logic                    frame_good;

    // RGB565 low-order bits are intentionally discarded when packing to RGB444
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^{pixel_data[11], pixel_data[5], pixel_data[0]};

    // State register
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            state_q   <= ST_SYNC;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next state: transitions only at frame_done so a frame in progress is never cut
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | snapshot_req;
        case (state_q)
            ST_SYNC: begin
                if (frame_done) state_d = live_mode ? ST_CAPTURE : ST_HOLD;
            end
            ST_CAPTURE: begin
                if (frame_done) begin
                    state_d   = (live_mode || pending_q) ? ST_CAPTURE : ST_HOLD;
                    // A pending snapshot is spent on the frame that just ended
                    pending_d = snapshot_req;
                end
            end
            ST_HOLD: begin
                if (frame_done && (pending_q || live_mode || snapshot_req)) begin
                    state_d   = ST_CAPTURE;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_SYNC;
                pending_d = 1'b0;
            end
        endcase
    end

    // Output/datapath decode: which pixel is written, frame totals at frame end
    always_comb begin
        in_capture  = (state_q == ST_CAPTURE);
        busy        = in_capture;
        holding     = (state_q == ST_HOLD);
        accept      = in_capture && pixel_valid && (pix_cnt_q != PIX_FULL);
        drop        = in_capture && pixel_valid && (pix_cnt_q == PIX_FULL);
        cnt_end     = accept ? (pix_cnt_q + 1'b1) : pix_cnt_q;
        ovf_end     = ovf_q | drop;
        seen_end    = (in_capture && pixel_valid && (seen_q != SEEN_MAX)) ? (seen_q + 1'b1) : seen_q;
        end_capture = in_capture && frame_done;
        frame_good  = (cnt_end == PIX_FULL) && !ovf_end;
    end

    // Registered write port, status pulses and per-frame counters
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_en       <= 1'b0;
            frame_ready <= 1'b0;
            frame_error <= 1'b0;
            pix_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            seen_q      <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= pix_cnt_q;
                wr_data <= {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
            end
            frame_ready <= end_capture && frame_good;
            frame_error <= end_capture && !frame_good;
            if (end_capture) begin
                pix_cnt_q <= '0;
                ovf_q     <= 1'b0;
                seen_q    <= '0;
            end else begin
                pix_cnt_q <= cnt_end;
                ovf_q     <= ovf_end;
                seen_q    <= seen_end;
            end
        end
    end

`ifdef CAMERA_FRAME_STATS_EN
    // Good-frame counter and size of the most recent captured frame
    always_ff @(posedge pixel_clock_in) begin
        if (reset_in) begin
            frame_count      <= '0;
            last_pixel_count <= '0;
        end else if (end_capture) begin
            last_pixel_count <= seen_end;
            if (frame_good) frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_camera_frame_sequencer.sv
// tb/tb_camera_frame_sequencer.sv - randomized self-checking bench for camera_frame_sequencer
module tb_camera_frame_sequencer;

    localparam int FP = 100;
    localparam int AW = 17;
    localparam int M_SYNC = 0;
    localparam int M_CAP  = 1;
    localparam int M_HOLD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   pixel_data = '0;
    logic          pixel_valid = 1'b0;
    logic          frame_done = 1'b0;
    logic          live_mode = 1'b0;
    logic          snapshot_req = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          wr_en;
    logic          frame_ready;
    logic          frame_error;
    logic          busy;
    logic          holding;
`ifdef CAMERA_FRAME_STATS_EN
    logic [15:0]   frame_count;
    logic [16:0]   last_pixel_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_mode;
    int          m_n;
    bit          m_pending;
    int          m_good;
    int          m_last;
    bit          exp_wr_en, exp_ready, exp_error, exp_busy, exp_holding;
    int          exp_addr;
    logic [11:0] exp_data;

    camera_frame_sequencer #(.FRAME_PIXELS(FP), .ADDR_WIDTH(AW)) dut (
        .pixel_clock_in (clk),
        .reset_in       (rst),
        .pixel_data     (pixel_data),
        .pixel_valid    (pixel_valid),
        .frame_done     (frame_done),
        .live_mode      (live_mode),
        .snapshot_req   (snapshot_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .frame_ready    (frame_ready),
        .frame_error    (frame_error),
        .busy           (busy),
        .holding        (holding)
`ifdef CAMERA_FRAME_STATS_EN
        ,.frame_count      (frame_count)
        ,.last_pixel_count (last_pixel_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to444(input logic [15:0] d);
        int r, g, b;
        r = int'(d) / 4096;
        g = (int'(d) / 128) % 16;
        b = (int'(d) / 2) % 16;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    task automatic model_reset();
        m_mode = M_SYNC; m_n = 0; m_pending = 0; m_good = 0; m_last = 0;
        exp_wr_en = 0; exp_ready = 0; exp_error = 0; exp_busy = 0; exp_holding = 0;
        exp_addr = 0; exp_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; pixel_valid = 0; frame_done = 0; snapshot_req = 0; live_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of inputs and advance the model by one clock
    task automatic step(input bit v, input bit fd, input bit lv, input bit rq);
        logic [15:0] d;
        d = 16'($urandom);
        pixel_data = d; pixel_valid = v; frame_done = fd; live_mode = lv; snapshot_req = rq;
        exp_wr_en = (m_mode == M_CAP) && v && (m_n < FP);
        if (exp_wr_en) begin
            exp_addr = m_n;
            exp_data = to444(d);
        end
        if (m_mode == M_CAP && v) m_n++;
        exp_ready = 0; exp_error = 0;
        if (fd && m_mode == M_CAP) begin
            if (m_n == FP) begin
                exp_ready = 1;
                m_good = (m_good + 1) % 65536;
            end else begin
                exp_error = 1;
            end
            m_last = (m_n > 131071) ? 131071 : m_n;
            m_n = 0;
        end
        case (m_mode)
            M_SYNC: begin
                if (rq) m_pending = 1;
                if (fd) m_mode = lv ? M_CAP : M_HOLD;
            end
            M_CAP: begin
                if (fd) begin
                    m_mode = (lv || m_pending) ? M_CAP : M_HOLD;
                    m_pending = rq;
                end else if (rq) m_pending = 1;
            end
            default: begin
                if (fd && (m_pending || lv || rq)) begin
                    m_mode = M_CAP;
                    m_pending = 0;
                end else if (rq) m_pending = 1;
            end
        endcase
        exp_busy = (m_mode == M_CAP);
        exp_holding = (m_mode == M_HOLD);
        @(posedge clk);
        #1;
        pixel_valid = 0; frame_done = 0; snapshot_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if ({frame_ready, frame_error} !== 2'b00) begin errors++; $display("FAIL reset_status got %b%b want 00", frame_ready, frame_error); end
        checks++; if ({busy, holding} !== 2'b00) begin errors++; $display("FAIL reset_state got busy=%b holding=%b want 0 0", busy, holding); end
`ifdef CAMERA_FRAME_STATS_EN
        checks++; if (frame_count !== 16'd0 || last_pixel_count !== 17'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", frame_count, last_pixel_count); end
`endif
    endtask

    task automatic test_live();
        step(0, 1, 1, 0);
        checks++; if (busy !== 1'b1 || holding !== 1'b0) begin errors++; $display("FAIL live_enter got busy=%b holding=%b want 1 0", busy, holding); end
        for (int i = 0; i < FP; i++) begin
            step(1, 0, 1, 0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== exp_data) begin
                errors++; $display("FAIL live_write got en=%b addr=%0d data=%h want 1 %0d %h", wr_en, wr_addr, wr_data, i, exp_data);
            end
        end
        step(0, 1, 1, 0);
        checks++; if (frame_ready !== 1'b1 || frame_error !== 1'b0) begin errors++; $display("FAIL live_ready got rdy=%b err=%b want 1 0", frame_ready, frame_error); end
`ifdef CAMERA_FRAME_STATS_EN
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL live_frame_count got %0d want 1", frame_count); end
`endif
        step(0, 0, 1, 0);
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL live_ready_pulse got %b want 0", frame_ready); end
    endtask

    task automatic test_short();
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 1, 0);
            checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(i)) begin errors++; $display("FAIL short_write got en=%b addr=%0d want 1 %0d", wr_en, wr_addr, i); end
        end
        step(0, 1, 1, 0);
        checks++; if (frame_error !== 1'b1 || frame_ready !== 1'b0) begin errors++; $display("FAIL short_status got rdy=%b err=%b want 0 1", frame_ready, frame_error); end
`ifdef CAMERA_FRAME_STATS_EN
        checks++; if (last_pixel_count !== 17'd30) begin errors++; $display("FAIL short_last_count got %0d want 30", last_pixel_count); end
`endif
        step(1, 0, 1, 0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== '0) begin errors++; $display("FAIL short_restart got en=%b addr=%0d want 1 0", wr_en, wr_addr); end
        step(0, 1, 1, 0);
    endtask

    task automatic test_overflow();
        int writes, last_addr;
        writes = 0; last_addr = -1;
        for (int i = 0; i < FP + 5; i++) begin
            step(1, 0, 1, 0);
            if (wr_en === 1'b1) begin writes++; last_addr = int'(wr_addr); end
            checks++; if (wr_en !== exp_wr_en) begin errors++; $display("FAIL ovf_wr_en at %0d got %b want %b", i, wr_en, exp_wr_en); end
        end
        checks++; if (writes != FP || last_addr != FP - 1) begin errors++; $display("FAIL ovf_writes got %0d last %0d want %0d last %0d", writes, last_addr, FP, FP - 1); end
        step(0, 1, 1, 0);
        checks++; if (frame_error !== 1'b1 || frame_ready !== 1'b0) begin errors++; $display("FAIL ovf_status got rdy=%b err=%b want 0 1", frame_ready, frame_error); end
`ifdef CAMERA_FRAME_STATS_EN
        checks++; if (last_pixel_count !== 17'(FP + 5)) begin errors++; $display("FAIL ovf_last_count got %0d want %0d", last_pixel_count, FP + 5); end
`endif
    endtask

    task automatic test_snapshot();
        step(0, 1, 0, 0);
        checks++; if (holding !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL snap_hold got holding=%b busy=%b want 1 0", holding, busy); end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL snap_hold_write got %b want 0", wr_en); end
        end
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL snap_start got busy=%b want 1", busy); end
        for (int i = 0; i < FP; i++) begin
            step(1, 0, 0, 0);
            checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(i)) begin errors++; $display("FAIL snap_write got en=%b addr=%0d want 1 %0d", wr_en, wr_addr, i); end
        end
        step(0, 1, 0, 0);
        checks++; if (frame_ready !== 1'b1 || holding !== 1'b1) begin errors++; $display("FAIL snap_done got rdy=%b holding=%b want 1 1", frame_ready, holding); end
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL snap_frozen got %b want 0", wr_en); end
        end
        step(0, 1, 0, 0);
        checks++; if (holding !== 1'b1 || frame_ready !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL snap_stay got holding=%b rdy=%b err=%b want 1 0 0", holding, frame_ready, frame_error); end
    endtask

    task automatic test_coincident();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coinc_req got busy=%b want 1", busy); end
        for (int i = 0; i < FP - 1; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(FP - 1)) begin errors++; $display("FAIL coinc_last_write got en=%b addr=%0d want 1 %0d", wr_en, wr_addr, FP - 1); end
        checks++; if (frame_ready !== 1'b1 || frame_error !== 1'b0 || holding !== 1'b1) begin errors++; $display("FAIL coinc_status got rdy=%b err=%b holding=%b want 1 0 1", frame_ready, frame_error, holding); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        step(0, 1, 1, 0);
        for (int i = 0; i < 50; i++) step(1, 0, 1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({wr_en, frame_ready, frame_error, busy, holding} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++; $display("FAIL midreset_outputs got en=%b rdy=%b err=%b busy=%b hold=%b addr=%0d data=%h want all 0", wr_en, frame_ready, frame_error, busy, holding, wr_addr, wr_data);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 0);
            checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_sync got en=%b busy=%b want 0 0", wr_en, busy); end
        end
        step(0, 1, 1, 0);
        checks++; if (busy !== 1'b1 || frame_ready !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL midreset_resync got busy=%b rdy=%b err=%b want 1 0 0", busy, frame_ready, frame_error); end
    endtask

    task automatic test_random();
        bit lv;
        do_reset();
        lv = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            bit v, fd, rq;
            if ($urandom_range(0, 299) == 0) lv = ~lv;
            v  = ($urandom_range(0, 9) < 7);
            fd = (m_n >= FP - 2) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 149) == 0);
            rq = ($urandom_range(0, 59) == 0);
            step(v, fd, lv, rq);
            checks++;
            if (wr_en !== exp_wr_en || (exp_wr_en && (wr_addr !== AW'(exp_addr) || wr_data !== exp_data))) begin
                errors++; $display("FAIL rand_write cyc %0d got en=%b addr=%0d data=%h want %b %0d %h", c, wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
            end
            checks++;
            if (frame_ready !== exp_ready || frame_error !== exp_error || busy !== exp_busy || holding !== exp_holding) begin
                errors++; $display("FAIL rand_status cyc %0d got rdy=%b err=%b busy=%b hold=%b want %b %b %b %b", c, frame_ready, frame_error, busy, holding, exp_ready, exp_error, exp_busy, exp_holding);
            end
`ifdef CAMERA_FRAME_STATS_EN
            checks++;
            if (frame_count !== 16'(m_good) || last_pixel_count !== 17'(m_last)) begin
                errors++; $display("FAIL rand_stats cyc %0d got %0d/%0d want %0d/%0d", c, frame_count, last_pixel_count, m_good, m_last);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_live();
        test_short();
        test_overflow();
        test_snapshot();
        test_coincident();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
